// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcode/funct
// constants, ALU operation codes, datapath mux selects, instruction classes
// and the per-state strobe decode.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Code 0 doubles as "no operation" so idle states drive alu_ctl low.
   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

   localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] REG_DST_RT  = 2'd0;
   localparam logic [1:0] REG_DST_RD  = 2'd1;
   localparam logic [1:0] REG_DST_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   typedef enum logic [3:0] {
      IC_ILLEGAL = 4'd0,
      IC_LW      = 4'd1,
      IC_SW      = 4'd2,
      IC_RALU    = 4'd3,
      IC_IMM     = 4'd4,
      IC_BEQ     = 4'd5,
      IC_BNE     = 4'd6,
      IC_J       = 4'd7,
      IC_JAL     = 4'd8,
      IC_JR      = 4'd9
   } iclass_t;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_b;
      logic       instr_done;
   } ctl_t;

   function automatic iclass_t classify(logic [5:0] op, logic [5:0] fn);
      iclass_t c;
      c = IC_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD, FN_SUB, FN_SLT: c = IC_RALU;
               FN_JR:                  c = IC_JR;
               default:                c = IC_ILLEGAL;
            endcase
         end
         OP_LW:            c = IC_LW;
         OP_SW:            c = IC_SW;
         OP_ADDI, OP_XORI: c = IC_IMM;
         OP_BEQ:           c = IC_BEQ;
         OP_BNE:           c = IC_BNE;
         OP_J:             c = IC_J;
         OP_JAL:           c = IC_JAL;
         default:          c = IC_ILLEGAL;
      endcase
      return c;
   endfunction

   // Strobes for a state; the branch pc_write is added live by the top.
   function automatic ctl_t state_ctl(state_t s, iclass_t c);
      ctl_t k;
      k = '0;
      case (s)
         S_FETCH: begin
            k.ir_write = 1'b1;
            k.pc_write = 1'b1;
            k.pc_src   = PC_SRC_SEQ;
         end
         S_MEM_ADDR: k.alu_src_b = 1'b1;
         S_MEM_RD:   k.mem_read  = 1'b1;
         S_MEM_WB: begin
            k.reg_write  = 1'b1;
            k.reg_dst    = REG_DST_RT;
            k.mem_to_reg = M2R_MEM;
            k.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            k.mem_write  = 1'b1;
            k.instr_done = 1'b1;
         end
         S_EXEC: k.alu_src_b = (c == IC_IMM);
         S_ALU_WB: begin
            k.reg_write  = 1'b1;
            k.reg_dst    = (c == IC_RALU) ? REG_DST_RD : REG_DST_RT;
            k.mem_to_reg = M2R_ALU;
            k.instr_done = 1'b1;
         end
         S_BRANCH: begin
            k.pc_src     = PC_SRC_BRANCH;
            k.instr_done = 1'b1;
         end
         S_JUMP: begin
            k.pc_write   = 1'b1;
            k.pc_src     = (c == IC_JR) ? PC_SRC_RS : PC_SRC_JUMP;
            k.instr_done = 1'b1;
            if (c == IC_JAL) begin
               k.reg_write  = 1'b1;
               k.reg_dst    = REG_DST_R31;
               k.mem_to_reg = M2R_PC4;
            end
         end
         default: k = '0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_control_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [1:0]  reg_dst;
   logic [1:0]  mem_to_reg;
   logic        alu_src_b;
   logic [3:0]  alu_ctl;
   logic [3:0]  state;
   logic        instr_done;
   logic [31:0] instr_count;
   logic        illegal;

   modport master (
      input  opcode, funct, zero,
      output ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
             reg_dst, mem_to_reg, alu_src_b, alu_ctl, state, instr_done,
             instr_count, illegal
   );

   modport slave (
      output opcode, funct, zero,
      input  ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
             reg_dst, mem_to_reg, alu_src_b, alu_ctl, state, instr_done,
             instr_count, illegal
   );
endinterface

// File: rtl/alu_decode.sv
// Combinational ALU operation select from the controller state and the
// opcode/funct latched at DECODE.
module alu_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctl
);

   // Address add for loads/stores, compare-subtract for branches, and the
   // instruction's own operation in EXEC.
   always_comb begin
      alu_ctl = ALU_NOP;
      case (state)
         S_MEM_ADDR: alu_ctl = ALU_ADD;
         S_BRANCH:   alu_ctl = ALU_SUB;
         S_EXEC: begin
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD:  alu_ctl = ALU_ADD;
                     FN_SUB:  alu_ctl = ALU_SUB;
                     FN_SLT:  alu_ctl = ALU_SLT;
                     default: alu_ctl = ALU_NOP;
                  endcase
               end
               OP_ADDI: alu_ctl = ALU_ADD;
               OP_XORI: alu_ctl = ALU_XOR;
               default: alu_ctl = ALU_NOP;
            endcase
         end
         default: alu_ctl = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM.
// Build option: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN -- when defined, an
// unrecognised instruction sets the sticky illegal flag and parks in HALT
// until reset; otherwise it retires as a two-cycle NOP.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | load IR, PC <= PC+4
// DECODE    | latch opcode/funct, dispatch by instruction class
// MEM_ADDR  | base + imm16 address add
// MEM_RD    | data-memory read
// MEM_WB    | load data -> rt (LW final)
// MEM_WR    | data-memory write (SW final)
// EXEC      | ALU op for R-type / ADDI / XORI
// ALU_WB    | ALU result -> rd or rt (final)
// BRANCH    | compare, conditional PC load (final)
// JUMP      | J / JAL / JR PC load, JAL links r31 (final)
// HALT      | illegal-instruction trap, left only by reset
module multicycle_control
   import cpu_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   multicycle_control_if.master bus
);

   state_t      state_q;
   state_t      state_d;
   logic [5:0]  op_q;
   logic [5:0]  fn_q;
   ctl_t        ctl_q;
   ctl_t        ctl_d;
   logic [31:0] instr_count_q;
   iclass_t     cls_live;
   iclass_t     cls_q;
   iclass_t     cls_eff;
   logic        nop_done;
   logic        branch_take;
   logic        retire;
   logic        illegal_flag;
   logic [3:0]  alu_ctl;

   // The IR is already loaded during DECODE, so the live opcode is valid
   // there; later states rely on the copy latched at the end of DECODE.
   assign cls_live = classify(bus.opcode, bus.funct);
   assign cls_q    = classify(op_q, fn_q);
   assign cls_eff  = (state_q == S_DECODE) ? cls_live : cls_q;

   // Next-state selection and the strobe set that state will present.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (cls_live)
               IC_LW, IC_SW:       state_d = S_MEM_ADDR;
               IC_RALU, IC_IMM:    state_d = S_EXEC;
               IC_BEQ, IC_BNE:     state_d = S_BRANCH;
               IC_J, IC_JAL, IC_JR: state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
               default:            state_d = S_HALT;
`else
               default:            state_d = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR: state_d = (cls_q == IC_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = S_MEM_WB;
         S_EXEC:     state_d = S_ALU_WB;
         S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
         S_HALT:     state_d = S_HALT;
`else
         S_HALT:     state_d = S_FETCH;
`endif
         default:    state_d = S_FETCH;
      endcase
      ctl_d = state_ctl(state_d, cls_eff);
   end

   // State register with registered strobes; reset lands in FETCH with
   // FETCH's strobes so the first edge after release performs the fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctl_q   <= state_ctl(S_FETCH, IC_ILLEGAL);
         op_q    <= 6'd0;
         fn_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
         end
      end
   end

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
   assign nop_done = 1'b0;

   // Sticky trap flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_flag <= 1'b0;
      end else if (state_q == S_DECODE && cls_live == IC_ILLEGAL) begin
         illegal_flag <= 1'b1;
      end
   end
`else
   assign nop_done     = (state_q == S_DECODE) && (cls_live == IC_ILLEGAL);
   assign illegal_flag = 1'b0;
`endif

   assign retire      = ctl_q.instr_done | nop_done;
   assign branch_take = (state_q == S_BRANCH) &&
                        ((cls_q == IC_BEQ && bus.zero) ||
                         (cls_q == IC_BNE && !bus.zero));

   // Retired-instruction counter, wraps naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_count_q <= 32'd0;
      end else if (retire) begin
         instr_count_q <= instr_count_q + 32'd1;
      end
   end

   alu_decode u_alu_decode (
      .state   (state_q),
      .opcode  (op_q),
      .funct   (fn_q),
      .alu_ctl (alu_ctl)
   );

   assign bus.ir_write    = ctl_q.ir_write;
   assign bus.pc_write    = ctl_q.pc_write | branch_take;
   assign bus.pc_src      = ctl_q.pc_src;
   assign bus.mem_read    = ctl_q.mem_read;
   assign bus.mem_write   = ctl_q.mem_write;
   assign bus.reg_write   = ctl_q.reg_write;
   assign bus.reg_dst     = ctl_q.reg_dst;
   assign bus.mem_to_reg  = ctl_q.mem_to_reg;
   assign bus.alu_src_b   = ctl_q.alu_src_b;
   assign bus.alu_ctl     = alu_ctl;
   assign bus.state       = state_q;
   assign bus.instr_done  = retire;
   assign bus.instr_count = instr_count_q;
   assign bus.illegal     = illegal_flag;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  async active-high reset.
REQ-004 opcode  input  6  instr[31:26] from datapath IR; stable from DECODE onward.
REQ-005 funct  input  6  instr[5:0] from IR.
REQ-006 zero  input  1  ALU zero flag from the current cycle's compare.
REQ-007 ir_write  output  1  load IR from instruction memory.
REQ-008 pc_write  output  1  load PC this edge.
REQ-009 pc_src  output  2  0 = PC+4, 1 = branch target, 2 = {PC+4[31:28], addr26, 2'b00}, 3 = rs.
REQ-010 mem_read / mem_write  output  1 each  data-memory strobes.
REQ-011 reg_write  output  1  regfile write enable.
REQ-012 reg_dst  output  2  0 = rt, 1 = rd, 2 = r31.
REQ-013 mem_to_reg  output  2  0 = ALU result, 1 = memory data, 2 = PC+4.
REQ-014 alu_src_b  output  1  0 = rt data, 1 = sign-extended imm16.
REQ-015 alu_ctl  output  4  ALU operation code.
REQ-016 state  output  4  current state, debug.
REQ-017 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-018 instr_count  output  32  retired-instruction count.
REQ-019 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-020 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP, HALT.
REQ-021 FETCH: ir_write = 1, pc_write = 1, pc_src = 0; next state DECODE.
REQ-022 DECODE SHALL latch opcode/funct internally and dispatch as follows: LW (0x23) and SW (0x2B) to MEM_ADDR; R-type (0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2A, or ADDI (0x08), or XORI (0x0E) to EXEC; BEQ (0x04) and BNE (0x05) to BRANCH; J (0x02), JAL (0x03), or R-type funct JR (0x08) to JUMP.
REQ-023 MEM_ADDR: alu_src_b = 1, alu_ctl = ADD; next state MEM_RD for LW, MEM_WR for SW.
REQ-024 MEM_RD: mem_read = 1, then MEM_WB; MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1.
REQ-025 MEM_WR: mem_write = 1.
REQ-026 EXEC: alu_ctl decoded from the latched opcode/funct; alu_src_b = 1 for ADDI/XORI. ALU_WB: reg_write = 1, mem_to_reg = 0, reg_dst = 1 for R-type and 0 for immediates.
REQ-027 BRANCH: alu_ctl = SUB; pc_write = (BEQ & zero) | (BNE & ~zero); pc_src = 1.
REQ-028 JUMP: pc_write = 1; pc_src = 3 for JR, else 2. JAL additionally asserts reg_write, reg_dst = 2, mem_to_reg = 2.
REQ-029 Terminal states are MEM_WB, MEM_WR, ALU_WB, BRANCH, and JUMP. Each SHALL assert instr_done, return to FETCH, and increment instr_count, wrapping 0xFFFFFFFF to 0.
REQ-030 Latency in cycles: LW 5; SW, R-type, ADDI, XORI 4; BEQ, BNE, J, JAL, JR 3.
REQ-031 Every output not named for a state SHALL be 0 in that state. Outputs SHALL be a decode of the state register; only pc_write in BRANCH depends on a live input (zero).
REQ-032 Unrecognised opcode or funct at DECODE is handled per REQ-036.

Reset
REQ-033 On reset assertion, state SHALL go to FETCH, instr_count and illegal to 0, and the latched opcode/funct to 0, immediately and regardless of clk.
REQ-034 Reset mid-instruction SHALL abandon the instruction with no further strobes; no retire count is recorded for it.
REQ-035 The first FETCH SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-036 Illegal-instruction handling SHALL be controlled by macro MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction sets illegal = 1 and enters HALT. HALT has all strobes at 0 and is left only by reset.
- Undefined: an illegal instruction is a 2-cycle NOP (DECODE to FETCH) with instr_done = 1 and counted; illegal is tied to 0 and HALT is unreachable.

Structure
REQ-037 Package cpu_ctrl_pkg SHALL hold the state encoding, opcode and funct constants, alu_ctl codes, and the pc_src, reg_dst, and mem_to_reg encodings.
REQ-038 Sub-module alu_decode SHALL be purely combinational, mapping latched opcode/funct and the state to alu_ctl.

Verification
REQ-039 Reset, then LW: state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; mem_read is high in cycle 4 only; instr_done is high in cycle 5; instr_count = 1.
REQ-040 BEQ with zero = 1 gives pc_write = 1 and pc_src = 1 in cycle 3; BNE with zero = 1 gives pc_write = 0 in cycle 3.
REQ-041 JAL: cycle 3 has reg_write = 1, reg_dst = 2, mem_to_reg = 2, pc_src = 2. JR (op 0x00, funct 0x08): cycle 3 has pc_src = 3 and reg_write = 0.
REQ-042 Assert reset during MEM_RD: state becomes FETCH asynchronously, mem_read drops, and instr_count is unchanged.
REQ-043 Opcode 0x3F with the macro defined: illegal = 1, state held at HALT for 10 cycles. Without the macro: 2-cycle NOP and instr_count increments.
REQ-044 Preload instr_count = 0xFFFFFFFF via forced value, retire one SW: instr_count = 0.
